// File: rtl/player_mover.sv
// Debounced button-driven sprite mover with hold/auto-repeat stepping,
// collision and screen-bound refusal, and color cycling on the centre button.
module player_mover #(
    parameter int PWIDTH     = 12,
    parameter int PHEIGHT    = 12,
    parameter int H_START    = 314,
    parameter int V_START    = 234,
    parameter int COLOR_INIT = 1,
    parameter int DB_CYCLES  = 500000,
    parameter int RPT_DELAY  = 25000000,
    parameter int RPT_PERIOD = 2000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btnU,
    input  logic       btnD,
    input  logic       btnR,
    input  logic       btnL,
    input  logic       btnC,
    input  logic       block_up,
    input  logic       block_down,
    input  logic       block_left,
    input  logic       block_right,
    output logic [3:0] btns,
    output logic       step_tick,
    output logic [9:0] player_hPos,
    output logic [9:0] player_vPos,
    output logic [3:0] player_color,
    output logic       bump
);
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_HOLD   = 2'd1;
    localparam logic [1:0] S_REPEAT = 2'd2;

    logic [4:0]  raw;
    logic [4:0]  sync1_q;
    logic [4:0]  sync2_q;
    logic [4:0]  db_q;
    logic [4:0]  db_d;
    logic [31:0] dbcnt_q [5];
    logic [31:0] dbcnt_d [5];
    logic [3:0]  btns_q;
    logic [3:0]  btns_d;
    logic [1:0]  state_q;
    logic [1:0]  state_d;
    logic [31:0] cnt_q;
    logic [31:0] cnt_d;
    logic [3:0]  code_q;
    logic [3:0]  code_d;
    logic        step_req;
    logic        step_tick_q;
    logic [9:0]  hpos_q;
    logic [9:0]  hpos_d;
    logic [9:0]  vpos_q;
    logic [9:0]  vpos_d;
    logic        bump_q;
    logic        bump_d;
    logic        cprev_q;
    logic [3:0]  color_q;
    logic [3:0]  color_d;
    logic [10:0] vbot;
    logic [10:0] hright;

    // bit order: 0=U 1=D 2=R 3=L 4=C
    assign raw = {btnC, btnL, btnR, btnD, btnU};

    always_comb begin
        db_d = db_q;
        for (int i = 0; i < 5; i++) begin
            dbcnt_d[i] = '0;
            if (sync2_q[i] != db_q[i]) begin
                if (dbcnt_q[i] == 32'(DB_CYCLES - 1)) begin
                    db_d[i] = sync2_q[i];
                end else begin
                    dbcnt_d[i] = dbcnt_q[i] + 32'd1;
                end
            end
        end
    end

    always_comb begin
        unique case (db_q[3:0])
            4'b0001: btns_d = 4'd8;
            4'b0010: btns_d = 4'd4;
            4'b0100: btns_d = 4'd2;
            4'b1000: btns_d = 4'd1;
            default: btns_d = 4'd0;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        code_d   = code_q;
        step_req = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (btns_q != 4'd0) begin
                    step_req = 1'b1;
                    cnt_d    = '0;
                    code_d   = btns_q;
                    state_d  = S_HOLD;
                end
            end
            S_HOLD: begin
                if (btns_q == 4'd0) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else if (btns_q != code_q) begin
                    step_req = 1'b1;
                    cnt_d    = '0;
                    code_d   = btns_q;
                end else if (cnt_q == 32'(RPT_DELAY - 1)) begin
                    step_req = 1'b1;
                    cnt_d    = '0;
                    state_d  = S_REPEAT;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            S_REPEAT: begin
                if (btns_q == 4'd0) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else if (btns_q != code_q) begin
                    step_req = 1'b1;
                    cnt_d    = '0;
                    code_d   = btns_q;
                    state_d  = S_HOLD;
                end else if (cnt_q == 32'(RPT_PERIOD - 1)) begin
                    step_req = 1'b1;
                    cnt_d    = '0;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    // 11-bit sums so the far-edge tests cannot overflow
    assign vbot   = {1'b0, vpos_q} + 11'(PHEIGHT);
    assign hright = {1'b0, hpos_q} + 11'(PWIDTH);

    always_comb begin
        hpos_d = hpos_q;
        vpos_d = vpos_q;
        bump_d = 1'b0;
        if (step_tick_q) begin
            case (btns_q)
                4'd8: begin
                    if (!block_up && vpos_q != 10'd0) vpos_d = vpos_q - 10'd1;
                    else bump_d = 1'b1;
                end
                4'd4: begin
                    if (!block_down && vbot < 11'd480) vpos_d = vpos_q + 10'd1;
                    else bump_d = 1'b1;
                end
                4'd2: begin
                    if (!block_right && hright < 11'd640) hpos_d = hpos_q + 10'd1;
                    else bump_d = 1'b1;
                end
                4'd1: begin
                    if (!block_left && hpos_q != 10'd0) hpos_d = hpos_q - 10'd1;
                    else bump_d = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        color_d = color_q + {3'b000, db_q[4] & ~cprev_q};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            db_q        <= '0;
            for (int i = 0; i < 5; i++) dbcnt_q[i] <= '0;
            btns_q      <= '0;
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            code_q      <= '0;
            step_tick_q <= 1'b0;
            hpos_q      <= 10'(H_START);
            vpos_q      <= 10'(V_START);
            bump_q      <= 1'b0;
            cprev_q     <= 1'b0;
            color_q     <= 4'(COLOR_INIT);
        end else begin
            sync1_q     <= raw;
            sync2_q     <= sync1_q;
            db_q        <= db_d;
            for (int i = 0; i < 5; i++) dbcnt_q[i] <= dbcnt_d[i];
            btns_q      <= btns_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            code_q      <= code_d;
            step_tick_q <= step_req;
            hpos_q      <= hpos_d;
            vpos_q      <= vpos_d;
            bump_q      <= bump_d;
            cprev_q     <= db_q[4];
            color_q     <= color_d;
        end
    end

    assign btns         = btns_q;
    assign step_tick    = step_tick_q;
    assign player_hPos  = hpos_q;
    assign player_vPos  = vpos_q;
    assign player_color = color_q;
    assign bump         = bump_q;

endmodule

// File: tb/tb_player_mover.sv
// Randomized bench for player_mover against an event-rule reference model.
module tb_player_mover;
    localparam int DB = 4;
    localparam int RD = 20;
    localparam int RP = 5;

    logic       clk;
    logic       rst_n;
    logic       btnU, btnD, btnR, btnL, btnC;
    logic       block_up, block_down, block_left, block_right;
    logic [3:0] btns;
    logic       step_tick;
    logic [9:0] player_hPos;
    logic [9:0] player_vPos;
    logic [3:0] player_color;
    logic       bump;

    int n_checks = 0;
    int n_fail   = 0;

    player_mover #(
        .DB_CYCLES (DB),
        .RPT_DELAY (RD),
        .RPT_PERIOD(RP)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .btnU        (btnU),
        .btnD        (btnD),
        .btnR        (btnR),
        .btnL        (btnL),
        .btnC        (btnC),
        .block_up    (block_up),
        .block_down  (block_down),
        .block_left  (block_left),
        .block_right (block_right),
        .btns        (btns),
        .step_tick   (step_tick),
        .player_hPos (player_hPos),
        .player_vPos (player_vPos),
        .player_color(player_color),
        .bump        (bump)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: synchronizer delay, run-length debounce, then
    // steps scheduled by how long the current code has been held.
    int m_s1 [5];
    int m_s2 [5];
    int m_st [5];
    int m_run[5];
    int m_btns, m_code, m_hold, m_tick, m_h, m_v, m_color, m_cprev, m_bump;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 5; i++) begin
                m_s1[i] = 0; m_s2[i] = 0; m_st[i] = 0; m_run[i] = 0;
            end
            m_btns = 0; m_code = 0; m_hold = 0; m_tick = 0;
            m_h = 314; m_v = 234; m_color = 1; m_cprev = 0; m_bump = 0;
        end else begin
            int raw[5];
            int n;
            raw[0] = int'(btnU); raw[1] = int'(btnD); raw[2] = int'(btnR);
            raw[3] = int'(btnL); raw[4] = int'(btnC);
            m_bump = 0;
            if (m_tick != 0) begin
                if (m_btns == 8) begin
                    if (!block_up && m_v > 0) m_v = m_v - 1; else m_bump = 1;
                end else if (m_btns == 4) begin
                    if (!block_down && m_v + 12 < 480) m_v = m_v + 1; else m_bump = 1;
                end else if (m_btns == 2) begin
                    if (!block_right && m_h + 12 < 640) m_h = m_h + 1; else m_bump = 1;
                end else if (m_btns == 1) begin
                    if (!block_left && m_h > 0) m_h = m_h - 1; else m_bump = 1;
                end
            end
            m_tick = 0;
            if (m_btns == 0) begin
                m_code = 0; m_hold = 0;
            end else if (m_btns != m_code) begin
                m_code = m_btns; m_hold = 0; m_tick = 1;
            end else begin
                m_hold = m_hold + 1;
                if (m_hold == RD) m_tick = 1;
                if (m_hold > RD && (m_hold - RD) % RP == 0) m_tick = 1;
            end
            if (m_st[4] != 0 && m_cprev == 0) m_color = (m_color + 1) % 16;
            m_cprev = m_st[4];
            n = m_st[0] + m_st[1] + m_st[2] + m_st[3];
            if (n != 1) m_btns = 0;
            else if (m_st[0] != 0) m_btns = 8;
            else if (m_st[1] != 0) m_btns = 4;
            else if (m_st[2] != 0) m_btns = 2;
            else m_btns = 1;
            for (int i = 0; i < 5; i++) begin
                if (m_s2[i] != m_st[i]) begin
                    m_run[i] = m_run[i] + 1;
                    if (m_run[i] == DB) begin
                        m_st[i] = m_s2[i]; m_run[i] = 0;
                    end
                end else begin
                    m_run[i] = 0;
                end
            end
            for (int i = 0; i < 5; i++) begin
                m_s2[i] = m_s1[i]; m_s1[i] = raw[i];
            end
        end
    end

    logic [29:0] dvec;
    logic [29:0] mvec;
    logic [29:0] rvec;
    assign dvec = {btns, step_tick, player_hPos, player_vPos, player_color, bump};
    assign mvec = {m_btns[3:0], m_tick[0], m_h[9:0], m_v[9:0], m_color[3:0], m_bump[0]};
    assign rvec = {4'd0, 1'b0, 10'd314, 10'd234, 4'd1, 1'b0};

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_btns(input logic [4:0] b);
        {btnC, btnL, btnR, btnD, btnU} = b;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        set_btns(5'b0);
        {block_up, block_down, block_left, block_right} = 4'b0;
        repeat (3) tick();
        n_checks++;
        if (dvec !== rvec) begin
            n_fail++;
            $display("FAIL reset_state: got %h want %h", dvec, rvec);
        end
        rst_n = 1'b1;
        tick();
        n_checks++;
        if (dvec !== rvec) begin
            n_fail++;
            $display("FAIL reset_release: got %h want %h", dvec, rvec);
        end
    endtask

    task automatic test_move_right();
        int st[$];
        set_btns(5'b00100);
        for (int c = 1; c <= 45; c++) begin
            tick();
            if (step_tick) st.push_back(c);
            n_checks++;
            if (dvec !== mvec) begin
                n_fail++;
                $display("FAIL move_right c=%0d: got %h want %h", c, dvec, mvec);
            end
            if (c == 9) begin
                n_checks++;
                if (player_hPos !== 10'd315 || btns !== 4'd2) begin
                    n_fail++;
                    $display("FAIL first_step: got h=%0d btns=%0d want 315/2",
                             player_hPos, btns);
                end
            end
        end
        n_checks++;
        if (st.size() != 5 || st[0] != 8 || st[1] - st[0] != RD ||
            st[2] - st[1] != RP || st[3] - st[2] != RP) begin
            n_fail++;
            $display("FAIL repeat_timing: got %0d ticks %p want 8,28,33,38,43",
                     st.size(), st);
        end
        n_checks++;
        if (player_hPos !== 10'd319) begin
            n_fail++;
            $display("FAIL hold_pos: got %0d want 319", player_hPos);
        end
        set_btns(5'b0);
        repeat (15) tick();
    endtask

    task automatic test_glitch();
        int h0 = m_h;
        int v0 = m_v;
        set_btns(5'b00001);
        repeat (2) tick();
        set_btns(5'b0);
        for (int c = 0; c < 20; c++) begin
            tick();
            n_checks++;
            if (btns !== 4'd0 || step_tick !== 1'b0 ||
                player_hPos !== 10'(h0) || player_vPos !== 10'(v0)) begin
                n_fail++;
                $display("FAIL glitch c=%0d: got btns=%0d tick=%b h=%0d v=%0d want 0/0/%0d/%0d",
                         c, btns, step_tick, player_hPos, player_vPos, h0, v0);
            end
        end
    endtask

    task automatic test_block_left();
        int h0 = m_h;
        int nt = 0;
        int nb = 0;
        block_left = 1'b1;
        set_btns(5'b01000);
        for (int c = 0; c < 40; c++) begin
            tick();
            nt += int'(step_tick);
            nb += int'(bump);
            n_checks++;
            if (dvec !== mvec || player_hPos !== 10'(h0)) begin
                n_fail++;
                $display("FAIL block_left c=%0d: got %h want %h h0=%0d",
                         c, dvec, mvec, h0);
            end
        end
        n_checks++;
        if (nt != 4 || nb != 4) begin
            n_fail++;
            $display("FAIL block_bumps: got ticks=%0d bumps=%0d want 4/4", nt, nb);
        end
        set_btns(5'b0);
        block_left = 1'b0;
        repeat (15) tick();
    endtask

    task automatic test_combo();
        set_btns(5'b00101);
        for (int c = 0; c < 30; c++) begin
            tick();
            n_checks++;
            if (btns !== 4'd0 || step_tick !== 1'b0 || player_vPos !== 10'd234) begin
                n_fail++;
                $display("FAIL combo_hold c=%0d: got btns=%0d tick=%b v=%0d want 0/0/234",
                         c, btns, step_tick, player_vPos);
            end
        end
        set_btns(5'b00001);
        for (int c = 0; c < 15; c++) begin
            tick();
            n_checks++;
            if (dvec !== mvec) begin
                n_fail++;
                $display("FAIL combo_release c=%0d: got %h want %h", c, dvec, mvec);
            end
        end
        n_checks++;
        if (btns !== 4'd8 || player_vPos !== 10'd233) begin
            n_fail++;
            $display("FAIL combo_up: got btns=%0d v=%0d want 8/233", btns, player_vPos);
        end
        set_btns(5'b0);
        repeat (15) tick();
    endtask

    task automatic test_color();
        for (int k = 0; k < 16; k++) begin
            set_btns(5'b10000);
            repeat ($urandom_range(8, 14)) tick();
            set_btns(5'b0);
            repeat ($urandom_range(8, 14)) tick();
            n_checks++;
            if (player_color !== 4'((2 + k) % 16) || dvec !== mvec) begin
                n_fail++;
                $display("FAIL color k=%0d: got %0d want %0d", k, player_color, (2 + k) % 16);
            end
        end
    endtask

    task automatic test_edges();
        int nb = 0;
        set_btns(5'b00010);
        for (int c = 0; c < 1260; c++) begin
            tick();
            nb += int'(bump);
            n_checks++;
            if (dvec !== mvec) begin
                n_fail++;
                $display("FAIL edge_down c=%0d: got %h want %h", c, dvec, mvec);
            end
        end
        n_checks++;
        if (player_vPos !== 10'd468 || nb == 0) begin
            n_fail++;
            $display("FAIL bottom_edge: got v=%0d bumps=%0d want 468/>0", player_vPos, nb);
        end
        set_btns(5'b0);
        repeat (15) tick();
        nb = 0;
        set_btns(5'b00001);
        for (int c = 0; c < 2430; c++) begin
            tick();
            nb += int'(bump);
            n_checks++;
            if (dvec !== mvec) begin
                n_fail++;
                $display("FAIL edge_up c=%0d: got %h want %h", c, dvec, mvec);
            end
        end
        n_checks++;
        if (player_vPos !== 10'd0 || nb == 0) begin
            n_fail++;
            $display("FAIL top_edge: got v=%0d bumps=%0d want 0/>0", player_vPos, nb);
        end
        set_btns(5'b0);
        repeat (15) tick();
    endtask

    task automatic test_random();
        int seg = 0;
        for (int c = 0; c < 3000; c++) begin
            if (seg == 0) begin
                int r = $urandom_range(0, 9);
                logic [4:0] b;
                b = 5'b0;
                if (r <= 5) b[$urandom_range(0, 3)] = 1'b1;
                else if (r == 6) b[3:0] = 4'($urandom_range(0, 15));
                else if (r == 7) b[4] = 1'b1;
                set_btns(b);
                seg = $urandom_range(1, 60);
            end
            seg--;
            if ($urandom_range(0, 7) == 0)
                {block_up, block_down, block_left, block_right} = 4'($urandom_range(0, 15));
            tick();
            n_checks++;
            if (dvec !== mvec) begin
                n_fail++;
                $display("FAIL random c=%0d: got %h want %h", c, dvec, mvec);
            end
        end
        set_btns(5'b0);
        {block_up, block_down, block_left, block_right} = 4'b0;
        repeat (15) tick();
    endtask

    task automatic test_reset_mid();
        int first = -1;
        set_btns(5'b00100);
        repeat (50) tick();
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (dvec !== rvec) begin
            n_fail++;
            $display("FAIL reset_async: got %h want %h", dvec, rvec);
        end
        for (int c = 0; c < 3; c++) begin
            tick();
            n_checks++;
            if (dvec !== rvec) begin
                n_fail++;
                $display("FAIL reset_hold c=%0d: got %h want %h", c, dvec, rvec);
            end
        end
        rst_n = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            tick();
            if (step_tick && first < 0) first = c;
            n_checks++;
            if (dvec !== mvec) begin
                n_fail++;
                $display("FAIL reset_fresh c=%0d: got %h want %h", c, dvec, mvec);
            end
        end
        n_checks++;
        if (first != 8) begin
            n_fail++;
            $display("FAIL fresh_press: got first tick at %0d want 8", first);
        end
        set_btns(5'b0);
        repeat (10) tick();
    endtask

    initial begin
        test_reset();
        test_move_right();
        test_glitch();
        test_block_left();
        test_combo();
        test_color();
        test_edges();
        test_random();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
